// File: rtl/dino_motion_pkg.sv
// Shared constants and state encoding for the dino motion controller and renderer.
// The renderer's sprite logic imports the same ground line so both agree on where the dino stands.
package dino_motion_pkg;

    localparam int DINO_X       = 40;
    localparam int SPRITE_W     = 60;
    localparam int SPRITE_H     = 60;
    localparam int GROUND_LINE  = 335;
    localparam int GROUND_Y     = GROUND_LINE - SPRITE_H;
    localparam int MIN_Y        = 20;
    localparam int JUMP_V       = 12;
    localparam int GRAVITY      = 1;
    localparam int FAST_G       = 3;
    localparam int DEBOUNCE_CYC = 1000000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DUCK = 2'd1,
        JUMP = 2'd2
    } dino_state_e;

endpackage

// File: rtl/dino_motion_ctrl_debounce.sv
// Button debouncer: two-flop synchroniser followed by a stability counter.
// The output follows the synced input only after it has disagreed for DEBOUNCE_CYC straight cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the synced value agrees with the output restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino motion controller: debounced buttons, per-frame tick, and the run/duck/jump FSM
// that produces the sprite position consumed by the renderer.
module dino_motion_ctrl
    import dino_motion_pkg::*;
#(
    parameter int P_DINO_X       = DINO_X,
    parameter int P_GROUND_Y     = GROUND_Y,
    parameter int P_MIN_Y        = MIN_Y,
    parameter int P_JUMP_V       = JUMP_V,
    parameter int P_GRAVITY      = GRAVITY,
    parameter int P_FAST_G       = FAST_G,
    parameter int DEBOUNCE_CYC   = dino_motion_pkg::DEBOUNCE_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        screen_end,
    input  logic        game_over,
    output logic        up,
    output logic        down,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        airborne
);

    localparam logic signed [10:0] GROUND_Y_S = 11'(P_GROUND_Y);
    localparam logic signed [10:0] MIN_Y_S    = 11'(P_MIN_Y);
    localparam logic signed [7:0]  JUMP_V_S   = 8'(P_JUMP_V);
    localparam logic signed [7:0]  GRAVITY_S  = 8'(P_GRAVITY);
    localparam logic signed [7:0]  FAST_G_S   = 8'(P_FAST_G);

    logic upDb;
    logic downDb;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce_up (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_up),
        .level_o (upDb)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce_down (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_down),
        .level_o (downDb)
    );

    logic              screenEnd_q;
    logic              moveTick;
    dino_state_e       state_q;
    dino_state_e       state_d;
    logic signed [10:0] y_q;
    logic signed [10:0] y_d;
    logic signed [7:0]  vel_q;
    logic signed [7:0]  vel_d;
    logic signed [10:0] velExt;
    logic signed [10:0] yNext;

    // One tick per frame on the rising edge of screen_end; game_over suppresses it entirely.
    assign moveTick = screen_end & ~screenEnd_q & ~game_over;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            screenEnd_q <= 1'b0;
            state_q     <= RUN;
            y_q         <= GROUND_Y_S;
            vel_q       <= '0;
        end else begin
            screenEnd_q <= screen_end;
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
        end
    end

    assign velExt = {{3{vel_q[7]}}, vel_q};
    assign yNext  = y_q - velExt;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        if (moveTick) begin
            unique case (state_q)
                RUN: begin
                    if (downDb) begin
                        state_d = DUCK;
                    end else if (upDb) begin
                        state_d = JUMP;
                        vel_d   = JUMP_V_S;
                    end
                end
                DUCK: begin
                    if (!downDb) begin
                        state_d = RUN;
                    end
                end
                JUMP: begin
                    vel_d = vel_q - (downDb ? FAST_G_S : GRAVITY_S);
                    // Landing wins over relaunch: a held up button only acts on a later tick.
                    if (yNext >= GROUND_Y_S) begin
                        y_d     = GROUND_Y_S;
                        vel_d   = '0;
                        state_d = RUN;
                    end else if (yNext < MIN_Y_S) begin
                        y_d = MIN_Y_S;
                    end else begin
                        y_d = yNext;
                    end
                end
                default: begin
                    state_d = RUN;
                    y_d     = GROUND_Y_S;
                    vel_d   = '0;
                end
            endcase
        end
    end

    assign up       = upDb;
    assign down     = downDb & (state_q != JUMP);
    assign airborne = (state_q == JUMP);
    assign dino_x   = 32'(P_DINO_X);
    assign dino_y   = {22'd0, y_q[9:0]};

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Self-checking bench for dino_motion_ctrl: table of per-frame vectors plus hand-written
// sequences for reset, debounce timing and reset in mid-jump.
module tb_dino_motion_ctrl;

    logic        clk;
    logic        reset;
    logic        btn_up;
    logic        btn_down;
    logic        screen_end;
    logic        game_over;
    logic        up;
    logic        down;
    logic [31:0] dino_x;
    logic [31:0] dino_y;
    logic        airborne;

    int testsRun = 0;
    int failures = 0;

    dino_motion_ctrl #(.DEBOUNCE_CYC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .screen_end (screen_end),
        .game_over  (game_over),
        .up         (up),
        .down       (down),
        .dino_x     (dino_x),
        .dino_y     (dino_y),
        .airborne   (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic upBtn;
        logic downBtn;
        logic gameOver;
        int   expY;
        logic expAir;
        logic expUp;
        logic expDown;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(logic u, logic d, logic g, int y, logic a);
        vec_t v;
        v.upBtn    = u;
        v.downBtn  = d;
        v.gameOver = g;
        v.expY     = y;
        v.expAir   = a;
        v.expUp    = u;
        v.expDown  = d & ~a;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] got,
                               input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", name, idx, got, exp);
        end
    endtask

    // Settle the buttons well past debounce latency, then deliver one frame tick.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        btn_up    = v.upBtn;
        btn_down  = v.downBtn;
        game_over = v.gameOver;
        repeat (8) @(negedge clk);
        screen_end = 1'b1;
        repeat (2) @(negedge clk);
        screen_end = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int nomY[26] = '{275, 263, 252, 242, 233, 225, 218, 212, 207, 203, 200, 198, 197,
                     197, 198, 200, 203, 207, 212, 218, 225, 233, 242, 252, 263, 275};
    int fastY[8] = '{197, 200, 206, 215, 227, 242, 260, 275};

    initial begin
        reset      = 1'b1;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        screen_end = 1'b0;
        game_over  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset dino_y", 0, dino_y, 32'd275);
        checkOutput("reset dino_x", 0, dino_x, 32'd40);
        checkOutput("reset airborne", 0, {31'd0, airborne}, 32'd0);
        checkOutput("reset up", 0, {31'd0, up}, 32'd0);
        checkOutput("reset down", 0, {31'd0, down}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Three-cycle glitch must not get through the debouncer.
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("glitch up", 0, {31'd0, up}, 32'd0);

        // Held press appears exactly 2 + 4 clocks after the edge.
        btn_up = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("debounce up early", 0, {31'd0, up}, 32'd0);
        @(negedge clk);
        checkOutput("debounce up on time", 0, {31'd0, up}, 32'd1);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("debounce up release", 0, {31'd0, up}, 32'd0);
        checkOutput("no jump without tick", 0, {31'd0, airborne}, 32'd0);

        // Jump, then fast-fall from the apex with down held.
        addVec(1, 0, 0, 275, 1);
        for (int i = 1; i <= 12; i++) addVec(0, 0, 0, nomY[i], 1);
        for (int i = 0; i < 8; i++) addVec(0, 1, 0, fastY[i], (i < 7));
        addVec(0, 0, 0, 275, 0);
        // up+down on the ground ducks; releasing down returns to RUN, jump one tick later.
        addVec(1, 1, 0, 275, 0);
        addVec(1, 1, 0, 275, 0);
        addVec(1, 0, 0, 275, 0);
        // Nominal jump with up held throughout; landing tick stays RUN, next tick relaunches.
        addVec(1, 0, 0, 275, 1);
        for (int i = 1; i <= 25; i++) addVec(1, 0, 0, nomY[i], (i < 25));
        addVec(1, 0, 0, 275, 1);
        // Freeze mid-jump under game_over, then resume.
        for (int i = 1; i <= 5; i++) addVec(0, 0, 0, nomY[i], 1);
        for (int i = 0; i < 10; i++) addVec(0, 0, 1, 225, 1);
        addVec(0, 0, 0, 218, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput("dino_y", i, dino_y, 32'(vecs[i].expY));
            checkOutput("airborne", i, {31'd0, airborne}, {31'd0, vecs[i].expAir});
            checkOutput("up", i, {31'd0, up}, {31'd0, vecs[i].expUp});
            checkOutput("down", i, {31'd0, down}, {31'd0, vecs[i].expDown});
            checkOutput("dino_x", i, dino_x, 32'd40);
        end

        // Asynchronous reset in mid-jump with up held.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("pre-reset dino_y", 0, dino_y, 32'd218);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset dino_y", 0, dino_y, 32'd275);
        checkOutput("async reset airborne", 0, {31'd0, airborne}, 32'd0);
        checkOutput("async reset up", 0, {31'd0, up}, 32'd0);
        checkOutput("async reset down", 0, {31'd0, down}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        screen_end = 1'b1;
        repeat (2) @(negedge clk);
        screen_end = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post-reset tick dino_y", 0, dino_y, 32'd275);
        checkOutput("post-reset tick airborne", 0, {31'd0, airborne}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
